// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP32 adder controller.
package fp_add_pkg;

    localparam int FP_W = 32;

    localparam int STG_MASK  = 0;
    localparam int STG_ALIGN = 1;
    localparam int STG_ALU   = 2;
    localparam int STG_NORM  = 3;
    localparam int STG_PACK  = 4;
    localparam int NSTG      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MASK,
        ST_ALIGN,
        ST_ALU,
        ST_NORM,
        ST_PACK,
        ST_DONE
    } ctrl_state_e;

    // One-hot enable pattern for a datapath stage index
    function automatic logic [NSTG-1:0] stage_onehot(input int idx);
        stage_onehot = NSTG'(1) << idx;
    endfunction

endpackage

// File: rtl/fp_add_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the previous winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Scan from last+1 around the ring, stop at the first active request
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fp_add_ctrl.sv
// Controller sharing one unpipelined FP32 adder datapath among NREQ requesters.
// Optional build macro FP_ADD_CTRL_STATS_EN adds stat_ops / stat_stall counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; req_ready decoded from arbiter grant
// MASK     | stage_en[0] active
// ALIGN    | stage_en[1] active
// ALU      | stage_en[2] active
// NORM     | stage_en[3] active
// PACK     | stage_en[4] active; dp_result captured at end of cycle
// DONE     | rsp_valid high, waiting for rsp_ready
module fp_add_ctrl
    import fp_add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [FP_W-1:0]      rsp_result,
    output logic [FP_W-1:0]      dp_a,
    output logic [FP_W-1:0]      dp_b,
    output logic [NSTG-1:0]      stage_en,
    input  logic [FP_W-1:0]      dp_result,
    output logic                 busy
`ifdef FP_ADD_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_ops,
    output logic [31:0]          stat_stall
`endif
);

    ctrl_state_e     state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  cur_id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [FP_W-1:0] sel_a;
    logic [FP_W-1:0] sel_b;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req       (req_valid),
        .last      (last_grant),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Accept is only ever offered while idle
    always_comb begin
        req_ready = (state == ST_IDLE) ? grant : '0;
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[FP_W*i +: FP_W];
                sel_b = req_b[FP_W*i +: FP_W];
            end
        end
    end

    // Sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= IDW'(NREQ - 1);
            cur_id     <= '0;
            dp_a       <= '0;
            dp_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            stage_en   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        dp_a       <= sel_a;
                        dp_b       <= sel_b;
                        cur_id     <= grant_idx;
                        last_grant <= grant_idx;
                        stage_en   <= stage_onehot(STG_MASK);
                        busy       <= 1'b1;
                        state      <= ST_MASK;
                    end
                end
                ST_MASK: begin
                    stage_en <= stage_onehot(STG_ALIGN);
                    state    <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    stage_en <= stage_onehot(STG_ALU);
                    state    <= ST_ALU;
                end
                ST_ALU: begin
                    stage_en <= stage_onehot(STG_NORM);
                    state    <= ST_NORM;
                end
                ST_NORM: begin
                    stage_en <= stage_onehot(STG_PACK);
                    state    <= ST_PACK;
                end
                ST_PACK: begin
                    rsp_result <= dp_result;
                    rsp_id     <= cur_id;
                    rsp_valid  <= 1'b1;
                    stage_en   <= '0;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    stage_en  <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FP_ADD_CTRL_STATS_EN
    // Completed-operation and backpressure-cycle counters, free-running wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else if (state == ST_DONE) begin
            if (rsp_ready) stat_ops   <= stat_ops + 32'd1;
            else           stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Self-checking bench for fp_add_ctrl; also covers FP_ADD_CTRL_STATS_EN builds.
module tb_fp_add_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_result;
    logic [31:0]          dp_a;
    logic [31:0]          dp_b;
    logic [4:0]           stage_en;
    logic [31:0]          dp_result;
    logic                 busy;
`ifdef FP_ADD_CTRL_STATS_EN
    logic [31:0]          stat_ops;
    logic [31:0]          stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    int last_w;
    int exp_ops = 0;
    int exp_stall = 0;

    fp_add_ctrl #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .stage_en   (stage_en),
        .dp_result  (dp_result),
        .busy       (busy)
`ifdef FP_ADD_CTRL_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner = valid requester at the smallest ring distance past the last winner
    function automatic int pick(input logic [NREQ-1:0] m, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - last - 1 + 2 * NREQ) % NREQ;
            if (m[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic check_stats(input string tag);
`ifdef FP_ADD_CTRL_STATS_EN
        chk({tag, "_stat_ops"},   64'(stat_ops),   64'(exp_ops));
        chk({tag, "_stat_stall"}, 64'(stat_stall), 64'(exp_stall));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One complete transaction: accept, 5 stages, DONE with 'stall' low cycles
    task automatic op(input logic [NREQ-1:0] vmask, input int stall,
                      input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fres);
        int w;
        logic [31:0] a, b, res;
        rsp_ready = (stall == 0);
        req_valid = vmask;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        w = pick(vmask, last_w);
        if (fa != 32'h0) begin
            req_a[32*w +: 32] = fa;
            req_b[32*w +: 32] = fb;
        end
        a = req_a[32*w +: 32];
        b = req_b[32*w +: 32];
        dp_result = $urandom;
        #1;
        chk("accept_ready", 64'(req_ready), 64'(4'b0001 << w));
        chk("accept_busy",  64'(busy), 64'd0);
        chk("accept_stage", 64'(stage_en), 64'd0);
        chk("accept_rspv",  64'(rsp_valid), 64'd0);
        step();
        for (int s = 0; s < 5; s++) begin
            req_valid = 4'($urandom);
            dp_result = $urandom;
            if (s == 4 && fres != 32'h0) dp_result = fres;
            res = dp_result;
            #1;
            chk("stage_en",    64'(stage_en), 64'(5'b00001 << s));
            chk("stage_ready", 64'(req_ready), 64'd0);
            chk("stage_busy",  64'(busy), 64'd1);
            chk("stage_rspv",  64'(rsp_valid), 64'd0);
            chk("stage_dp_a",  64'(dp_a), 64'(a));
            chk("stage_dp_b",  64'(dp_b), 64'(b));
            step();
        end
        dp_result = $urandom;
        for (int c = 0; c <= stall; c++) begin
            req_valid = 4'($urandom);
            if (c == stall) rsp_ready = 1'b1;
            #1;
            chk("done_rspv",   64'(rsp_valid), 64'd1);
            chk("done_id",     64'(rsp_id), 64'(w));
            chk("done_result", 64'(rsp_result), 64'(res));
            chk("done_ready",  64'(req_ready), 64'd0);
            chk("done_stage",  64'(stage_en), 64'd0);
            chk("done_busy",   64'(busy), 64'd1);
            chk("done_dp_a",   64'(dp_a), 64'(a));
            if (c == stall) exp_ops++;
            else            exp_stall++;
            step();
        end
        last_w = w;
        req_valid = '0;
        #1;
        chk("post_rspv",  64'(rsp_valid), 64'd0);
        chk("post_busy",  64'(busy), 64'd0);
        chk("post_ready", 64'(req_ready), 64'd0);
        check_stats("post");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        dp_result = '0;
        last_w    = NREQ - 1;
        #12;
        chk("rst_ready",  64'(req_ready), 64'd0);
        chk("rst_rspv",   64'(rsp_valid), 64'd0);
        chk("rst_stage",  64'(stage_en), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_result", 64'(rsp_result), 64'd0);
        chk("rst_id",     64'(rsp_id), 64'd0);
        chk("rst_dp_a",   64'(dp_a), 64'd0);
        chk("rst_dp_b",   64'(dp_b), 64'd0);
        check_stats("rst");
        step();
        reset = 1'b0;
        step();

        // Single op from requester 1: 1.0 + 2.0 = 3.0
        op(4'b0010, 0, 32'h3F800000, 32'h40000000, 32'h40400000);

        // Idle window
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_stage", 64'(stage_en), 64'd0);
            chk("idle_ready", 64'(req_ready), 64'd0);
            chk("idle_busy",  64'(busy), 64'd0);
        end

        // Round-robin with all requesters valid (7-cycle spacing)
        for (int k = 0; k < 5; k++) op(4'b1111, 0, 32'h0, 32'h0, 32'h0);

        // Backpressure: 5 cycles low in DONE
        op(4'b0100, 5, 32'h0, 32'h0, 32'h0);

        // Three ops, second stalled 4 cycles
        op(4'b1111, 0, 32'h0, 32'h0, 32'h0);
        op(4'b1111, 4, 32'h0, 32'h0, 32'h0);
        op(4'b1111, 0, 32'h0, 32'h0, 32'h0);

        // Randomized masks and stalls
        for (int k = 0; k < 12; k++) begin
            logic [NREQ-1:0] m;
            m = 4'($urandom_range(1, 15));
            op(m, int'($urandom_range(0, 3)), 32'h0, 32'h0, 32'h0);
        end

        // Reset in the middle of ALU
        req_valid = 4'b1000;
        #1;
        step();
        req_valid = '0;
        step();
        step();
        chk("pre_rst_stage", 64'(stage_en), 64'b00100);
        reset = 1'b1;
        #1;
        chk("midrst_stage",  64'(stage_en), 64'd0);
        chk("midrst_busy",   64'(busy), 64'd0);
        chk("midrst_rspv",   64'(rsp_valid), 64'd0);
        chk("midrst_ready",  64'(req_ready), 64'd0);
        chk("midrst_result", 64'(rsp_result), 64'd0);
        exp_ops   = 0;
        exp_stall = 0;
        check_stats("midrst");
        step();
        reset  = 1'b0;
        last_w = NREQ - 1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        op(4'b1111, 1, 32'h0, 32'h0, 32'h0);
        chk("after_rst_first_id", 64'(last_w), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
